// File: rtl/mac_pkg.sv
// mac_pkg: shared defaults and saturation-limit helpers for mac_round_sat
package mac_pkg;
    localparam int DEF_PW    = 58;
    localparam int DEF_OW    = 24;
    localparam int DEF_SHIFT = 24;
    localparam int DEF_DEPTH = 4;

    function automatic logic signed [63:0] sat_max(input int ow);
        return (64'sd1 <<< (ow - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int ow);
        return -(64'sd1 <<< (ow - 1));
    endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word fall-through FIFO, write while full only succeeds with a same-edge read
// ports: clk, rst (sync high), wr_en/wr_data, rd_en/rd_data (head), full, empty
module sync_fifo_fwft #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic do_rd, do_wr;
    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rp];
    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= do_wr ? wp + AW'(1) : wp;
            rp  <= do_rd ? rp + AW'(1) : rp;
            cnt <= cnt + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end
    always_ff @(posedge clk)
        if (do_wr) mem[wp] <= wr_data;
endmodule

// File: rtl/mac_round_sat.sv
// mac_round_sat: round-shift, saturate and buffer multiply-add results
// ports: clk, rst (sync high), in_valid/in_data (no backpressure),
//        out_valid/out_ready/out_data (FWFT stream), sat_cnt, drop_cnt, overflow (sticky)
module mac_round_sat
    import mac_pkg::*;
#(
    parameter int PW    = DEF_PW,
    parameter int OW    = DEF_OW,
    parameter int SHIFT = DEF_SHIFT,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic signed [PW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_data,
    output logic [15:0]          sat_cnt,
    output logic [15:0]          drop_cnt,
    output logic                 overflow
);
    localparam logic signed [PW:0] HALF  = (PW+1)'(64'sd1 <<< (SHIFT - 1));
    localparam logic signed [PW:0] MAX_R = (PW+1)'(sat_max(OW));
    localparam logic signed [PW:0] MIN_R = (PW+1)'(sat_min(OW));
    logic signed [PW:0] ext, s1_data;
    logic s1_valid, hi, lo, full, empty, drop;
    logic [OW-1:0] sat_data, rd_data;
    // one guard bit so adding the rounding half can never wrap
    assign ext      = {in_data[PW-1], in_data};
    assign hi       = s1_data > MAX_R;
    assign lo       = s1_data < MIN_R;
    assign sat_data = hi ? MAX_R[OW-1:0] : lo ? MIN_R[OW-1:0] : s1_data[OW-1:0];
    // a full FIFO only frees a slot when the head is taken on the same edge
    assign drop      = s1_valid && full && !out_ready;
    assign out_valid = !empty;
    assign out_data  = rd_data;
    always_ff @(posedge clk) begin
        s1_data <= (ext + HALF) >>> SHIFT;
        if (rst) begin
            s1_valid <= 1'b0;
            sat_cnt  <= '0;
            drop_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            sat_cnt  <= sat_cnt + 16'(s1_valid && (hi || lo) && sat_cnt != 16'hFFFF);
            drop_cnt <= drop_cnt + 16'(drop && drop_cnt != 16'hFFFF);
            overflow <= overflow || drop;
        end
    end
    sync_fifo_fwft #(.WIDTH(OW), .DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (s1_valid),
        .wr_data(sat_data),
        .rd_en  (out_ready),
        .rd_data(rd_data),
        .full   (full),
        .empty  (empty)
    );
endmodule

// File: tb/tb_mac_round_sat.sv
// tb_mac_round_sat: directed checks of rounding, saturation, FIFO flow, drops and reset
module tb_mac_round_sat;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, out_valid, overflow;
    logic [57:0] in_data = '0;
    logic [23:0] out_data;
    logic [15:0] sat_cnt, drop_cnt;
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    mac_round_sat dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sat_cnt(sat_cnt), .drop_cnt(drop_cnt), .overflow(overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one isolated word through the pipe, consumed on the edge after it appears
    task automatic one_word(input string tag, input longint v, input logic [23:0] exp, input logic [15:0] exp_sat);
        in_valid = 1'b1;
        in_data  = 58'(v);
        tick();
        in_valid = 1'b0;
        check({tag, "_lat"}, 64'(out_valid), 64'd0);
        tick();
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"}, 64'(out_data), 64'(exp));
        check({tag, "_sat"}, 64'(sat_cnt), 64'(exp_sat));
        tick();
        check({tag, "_gone"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_sat", 64'(sat_cnt), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);

        one_word("half_up", 64'sd1 <<< 23, 24'h000001, 16'd0);
        one_word("neg_half", -(64'sd1 <<< 23), 24'h000000, 16'd0);
        one_word("neg_1p5", -(64'sd3 <<< 23), 24'hFFFFFF, 16'd0);
        one_word("max_edge", (64'sd1 <<< 47) - (64'sd1 <<< 24), 24'h7FFFFF, 16'd0);
        one_word("min_edge", -(64'sd1 <<< 47), 24'h800000, 16'd0);
        one_word("sat_hi", 64'sd1 <<< 47, 24'h7FFFFF, 16'd1);
        one_word("sat_lo", -(64'sd1 <<< 47) - (64'sd1 <<< 24), 24'h800000, 16'd2);

        // overflow: six back-to-back words into a stalled four-deep FIFO
        out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1;
            in_data  = 58'(longint'(i) <<< 24);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("ovf_drop", 64'(drop_cnt), 64'd2);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_sat", 64'(sat_cnt), 64'd2);
        check("ovf_head", 64'(out_data), 64'd1);
        tick();
        check("ovf_stable", 64'(out_data), 64'd1);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("ovf_valid", 64'(out_valid), 64'd1);
            check("ovf_order", 64'(out_data), 64'(k));
            tick();
        end
        check("ovf_empty", 64'(out_valid), 64'd0);

        // full FIFO streaming: read and write on the same edge, nothing dropped
        out_ready = 1'b0;
        for (int i = 10; i <= 14; i++) begin
            in_valid = 1'b1;
            in_data  = 58'(longint'(i) <<< 24);
            tick();
        end
        out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            in_data = 58'(longint'(15 + j) <<< 24);
            check("full_head", 64'(out_data), 64'(10 + j));
            tick();
        end
        in_valid = 1'b0;
        for (int k = 16; k <= 20; k++) begin
            check("full_drain", 64'(out_data), 64'(k));
            tick();
        end
        check("full_empty", 64'(out_valid), 64'd0);
        check("full_nodrop", 64'(drop_cnt), 64'd2);

        // reset with three buffered words and one in stage 1; in_valid during rst ignored
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = 58'(longint'(i) <<< 24);
            tick();
        end
        rst     = 1'b1;
        in_data = 58'(longint'(7) <<< 24);
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("mrst_valid", 64'(out_valid), 64'd0);
        check("mrst_sat", 64'(sat_cnt), 64'd0);
        check("mrst_drop", 64'(drop_cnt), 64'd0);
        check("mrst_ovf", 64'(overflow), 64'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mrst_stale", 64'(out_valid), 64'd0);
        end
        one_word("post_rst", 64'sd5 <<< 24, 24'h000005, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
